csr_access_unit: RTL

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/core_package.sv | 56 +++++
 rtl/csr_rmw_alu.sv | 26 ++
 rtl/csr_access_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/core_package.sv
// core_package: shared CSR address map, Zicsr operation encodings and access-unit states.
package core_package;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_CYCLE     = 12'hC00,
        CSR_TIME      = 12'hC01,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_TIMEH     = 12'hC81,
        CSR_INSTRETH  = 12'hC82,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12,
        CSR_MIMPID    = 12'hF13,
        CSR_MHARTID   = 12'hF14
    } csr_e;

    typedef enum logic [2:0] {
        CSR_OP_RSV0 = 3'b000,
        CSR_OP_RW   = 3'b001,
        CSR_OP_RS   = 3'b010,
        CSR_OP_RC   = 3'b011,
        CSR_OP_RSV4 = 3'b100,
        CSR_OP_RWI  = 3'b101,
        CSR_OP_RSI  = 3'b110,
        CSR_OP_RCI  = 3'b111
    } csr_op_e;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_READ,
        ACC_WRITE,
        ACC_RESP
    } csr_acc_state_e;

    function automatic logic is_csr(input logic [11:0] addr);
        return addr inside {CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
                            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE,
                            CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH, CSR_CYCLE, CSR_TIME,
                            CSR_INSTRET, CSR_CYCLEH, CSR_TIMEH, CSR_INSTRETH, CSR_MVENDORID,
                            CSR_MARCHID, CSR_MIMPID, CSR_MHARTID};
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu: combinational read-modify-write datapath for Zicsr operations.
module csr_rmw_alu
    import core_package::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  rs1_idx_i,
    input  csr_op_e     op_i,
    output logic [31:0] new_o,
    output logic        write_intent_o
);
    logic [31:0] operand;
    logic [1:0]  kind;

    // Immediate forms reuse the rs1 index field as a zero-extended uimm.
    assign operand = op_i[2] ? {27'd0, rs1_idx_i} : rs1_data_i;
    assign kind    = op_i[1:0];

    always_comb begin
        new_o          = kind == 2'b01 ? operand :
                         kind == 2'b10 ? old_i | operand :
                         kind == 2'b11 ? old_i & ~operand : old_i;
        write_intent_o = kind == 2'b01 || (kind != 2'b00 && rs1_idx_i != 5'd0);
    end

endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences a Zicsr instruction through read, optional write and response.
module csr_access_unit
    import core_package::*;
#(
    parameter logic CHECK_RO = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  funct3_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  rs1_idx_i,
    output logic [11:0] csr_addr_o,
    input  logic [31:0] csr_data_i,
    output logic [31:0] csr_w_data_o,
    output logic        csr_w_en_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] rd_data_o,
    output logic        illegal_o
);
    csr_acc_state_e state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] rs1_q, rs1_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] old_q, old_d;
    logic [31:0] new_q, new_d;
    logic        ill_q, ill_d;
    logic [31:0] alu_new;
    logic        write_intent;
    logic        illegal;

    csr_rmw_alu u_alu (
        .old_i          (csr_data_i),
        .rs1_data_i     (rs1_q),
        .rs1_idx_i      (idx_q),
        .op_i           (csr_op_e'(funct3_q)),
        .new_o          (alu_new),
        .write_intent_o (write_intent)
    );

    assign illegal = funct3_q[1:0] == 2'b00 || !is_csr(addr_q) ||
                     (CHECK_RO && write_intent && addr_q[11:10] == 2'b11);

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        rs1_d    = rs1_q;
        idx_d    = idx_q;
        old_d    = old_q;
        new_d    = new_q;
        ill_d    = ill_q;
        case (state_q)
            ACC_IDLE: if (req_valid_i) begin
                funct3_d = funct3_i;
                addr_d   = csr_addr_i;
                rs1_d    = rs1_data_i;
                idx_d    = rs1_idx_i;
                state_d  = ACC_READ;
            end
            ACC_READ: begin
                old_d   = illegal ? 32'd0 : csr_data_i;
                new_d   = alu_new;
                ill_d   = illegal;
                state_d = write_intent && !illegal ? ACC_WRITE : ACC_RESP;
            end
            ACC_WRITE: state_d = ACC_RESP;
            default:   state_d = resp_ready_i ? ACC_IDLE : ACC_RESP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ACC_IDLE;
            funct3_q <= 3'd0;
            addr_q   <= 12'd0;
            rs1_q    <= 32'd0;
            idx_q    <= 5'd0;
            old_q    <= 32'd0;
            new_q    <= 32'd0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            rs1_q    <= rs1_d;
            idx_q    <= idx_d;
            old_q    <= old_d;
            new_q    <= new_d;
            ill_q    <= ill_d;
        end
    end

    assign req_ready_o  = state_q == ACC_IDLE;
    assign csr_addr_o   = addr_q;
    assign csr_w_en_o   = state_q == ACC_WRITE;
    assign csr_w_data_o = csr_w_en_o ? new_q : 32'd0;
    assign resp_valid_o = state_q == ACC_RESP;
    assign rd_data_o    = resp_valid_o ? old_q : 32'd0;
    assign illegal_o    = resp_valid_o && ill_q;

endmodule
